// File: rtl/reg_writeback_stage_if.sv
// reg_writeback_stage_if: request, data-memory read and register-file write signals
// for the write-back stage; slave = the stage, master = its environment.
interface reg_writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NSRC   = 3,
    parameter int SEL_W  = 2,
    parameter int MEM_W  = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [NSRC*DATA_W-1:0] in_src;
    logic [ADDR_W-1:0]      in_dest;
    logic                   in_wen;
    logic                   in_sext;
    logic                   mem_rvalid;
    logic [MEM_W-1:0]       mem_rdata;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [1:0]             err;

    modport slave (
        input  in_valid, in_sel, in_src, in_dest, in_wen, in_sext, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, err
    );
    modport master (
        output in_valid, in_sel, in_src, in_dest, in_wen, in_sext, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, err
    );
endinterface

// File: rtl/reg_writeback_stage.sv
// reg_writeback_stage: selects a write-back source (or waits for a memory load with
// timeout), extends load data and issues a one-cycle register-file write.
module reg_writeback_stage #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int NSRC        = 3,
    parameter int SEL_W       = 2,
    parameter int MEM_SRC     = 1,
    parameter int MEM_W       = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter bit ZERO_REG    = 1'b1
) (
    input logic clk,
    input logic rst_n,
    reg_writeback_stage_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic               wen_q, wen_d;
    logic               sext_q, sext_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         err_q, err_d;
    logic [DATA_W-1:0]  sel_val;
    logic               sel_ok;

    function automatic logic wr_ok(input logic wen, input logic [ADDR_W-1:0] dest);
        return wen && !(ZERO_REG && dest == '0);
    endfunction

    function automatic logic [DATA_W-1:0] ext(input logic [MEM_W-1:0] v, input logic s);
        return s ? DATA_W'($signed(v)) : DATA_W'(v);
    endfunction

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NSRC; k++)
            if (int'(bus.in_sel) == k) sel_val = bus.in_src[k*DATA_W +: DATA_W];
        sel_ok = int'(bus.in_sel) < NSRC;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        wen_d   = wen_q;
        sext_d  = sext_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                if (!sel_ok) begin
                    err_d[0] = 1'b1;
                end else if (int'(bus.in_sel) == MEM_SRC) begin
                    dest_d = bus.in_dest;
                    wen_d  = bus.in_wen;
                    sext_d = bus.in_sext;
                    if (bus.mem_rvalid) begin
                        we_d = wr_ok(bus.in_wen, bus.in_dest);
                        if (we_d) begin
                            waddr_d = bus.in_dest;
                            wdata_d = ext(bus.mem_rdata, bus.in_sext);
                        end
                    end else begin
                        state_d = WAIT_MEM;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    we_d = wr_ok(bus.in_wen, bus.in_dest);
                    if (we_d) begin
                        waddr_d = bus.in_dest;
                        wdata_d = sel_val;
                    end
                end
            end
        end else begin
            // read data arriving on the timeout cycle still completes the load
            if (bus.mem_rvalid) begin
                state_d = IDLE;
                cnt_d   = '0;
                we_d    = wr_ok(wen_q, dest_q);
                if (we_d) begin
                    waddr_d = dest_q;
                    wdata_d = ext(bus.mem_rdata, sext_q);
                end
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                state_d  = IDLE;
                cnt_d    = '0;
                err_d[1] = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            wen_q   <= 1'b0;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            wen_q   <= wen_d;
            sext_q  <= sext_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_reg_writeback_stage.sv
// tb_reg_writeback_stage: directed and random write-back requests; expected register
// writes are queued at issue time and matched by a monitor against each rf_we pulse.
module tb_reg_writeback_stage;
    localparam int DATA_W = 16, ADDR_W = 3, NSRC = 3, SEL_W = 2;
    localparam int MEM_SRC = 1, MEM_W = 8, MEM_TIMEOUT = 15;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wr_t  exp_q[$];
    wr_t  w_mon;
    logic [1:0] exp_err = 2'b00;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_writeback_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W),
                             .MEM_W(MEM_W)) bus ();

    reg_writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W),
                          .MEM_SRC(MEM_SRC), .MEM_W(MEM_W), .MEM_TIMEOUT(MEM_TIMEOUT),
                          .ZERO_REG(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load data as a number: values of 128 and above read as negative when signed.
    function automatic logic [DATA_W-1:0] load_val(input logic [MEM_W-1:0] rd, input logic sext);
        return (sext && rd >= 8'd128) ? DATA_W'(int'(rd) - 256) : DATA_W'(rd);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("err", 32'(bus.err), 32'(exp_err));
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rf_we", 32'(bus.rf_we), 32'd0);
                end else begin
                    w_mon = exp_q.pop_front();
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(w_mon.a));
                    chk("rf_wdata", 32'(bus.rf_wdata), 32'(w_mon.d));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 once the request (and its load) is done.
    // lat = cycle after accept in which mem_rvalid shows (0 = with the accept, >20 = never).
    task automatic txn(input int sel, input logic [DATA_W-1:0] s0, s1, s2,
                       input logic [ADDR_W-1:0] dest, input logic wen, sext,
                       input int lat, input logic [MEM_W-1:0] rd);
        logic [DATA_W-1:0] srcs [NSRC];
        int n;
        srcs = '{s0, s1, s2};
        bus.in_sel = SEL_W'(sel);
        bus.in_src = {s2, s1, s0};
        bus.in_dest = dest;
        bus.in_wen = wen;
        bus.in_sext = sext;
        bus.mem_rdata = rd;
        bus.mem_rvalid = (sel == MEM_SRC && lat == 0);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (sel >= NSRC) begin
            exp_err[0] = 1'b1;
        end else if (sel != MEM_SRC) begin
            if (wen && dest != 0) exp_q.push_back('{dest, srcs[sel]});
        end else begin
            if (lat <= MEM_TIMEOUT && wen && dest != 0) exp_q.push_back('{dest, load_val(rd, sext)});
            if (lat >= 1) begin
                chk("busy_in_wait", 32'(bus.in_ready), 32'd0);
                if (lat <= MEM_TIMEOUT) begin
                    repeat (lat - 1) begin @(posedge clk); #1; end
                    bus.mem_rvalid = 1'b1;
                    @(posedge clk);
                    #1 bus.mem_rvalid = 1'b0;
                end else begin
                    repeat (MEM_TIMEOUT) begin @(posedge clk); #1; end
                    exp_err[1] = 1'b1;
                    chk("ready_after_timeout", 32'(bus.in_ready), 32'd1);
                    if (lat <= 20) begin
                        repeat (lat - 1 - MEM_TIMEOUT) begin @(posedge clk); #1; end
                        bus.mem_rvalid = 1'b1;
                        @(posedge clk);
                        #1 bus.mem_rvalid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
        chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
        chk({tag, "_rf_wdata"}, 32'(bus.rf_wdata), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sel = '0;
        bus.in_src = '0;
        bus.in_dest = '0;
        bus.in_wen = 1'b0;
        bus.in_sext = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(0, 16'h1234, 16'h0, 16'h0, 3'd5, 1'b1, 1'b0, 0, 8'h00);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd3, 1'b1, 1'b1, 3, 8'h80);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 2, 8'h80);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd2, 1'b1, 1'b0, 1, 8'h80);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd4, 1'b1, 1'b1, 0, 8'h7F);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd6, 1'b1, 1'b1, MEM_TIMEOUT, 8'hC3);
        txn(1, 16'h0, 16'h0, 16'h0, 3'd7, 1'b1, 1'b1, 18, 8'h55);
        txn(3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd1, 1'b1, 1'b0, 0, 8'h00);
        txn(0, 16'hBEEF, 16'h1111, 16'h2222, 3'd1, 1'b1, 1'b0, 0, 8'h00);
        txn(2, 16'h3333, 16'h4444, 16'hCAFE, 3'd6, 1'b1, 1'b0, 0, 8'h00);
        txn(0, 16'h5A5A, 16'h0, 16'h0, 3'd7, 1'b0, 1'b0, 0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        // abandon a pending load with reset; its data must never be written
        bus.in_sel = SEL_W'(MEM_SRC);
        bus.in_dest = 3'd3;
        bus.in_wen = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_err = 2'b00;
        #1 chk_reset_outputs("mid_wait_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 8'h99;
        @(posedge clk);
        #1 bus.mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            int sel, lat;
            sel = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 22) : $urandom_range(0, 4);
            txn(sel, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                $urandom_range(0, 7) != 0, 1'($urandom), lat, 8'($urandom));
        end
        repeat (5) @(posedge clk);
        #1 chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
